data_memory_arbiter: RTL and testbench

//  Sequences shared data memory (DFFRAM_RTL_2048-style, 1-cycle sync read) between core LSU and SPI interface mem ctrl.

---
 rtl/data_memory_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Shares one single-port, 1-cycle-read data RAM between the core LSU and the SPI memory controller.
// Fixed core priority with an SPI anti-starvation override; one transaction in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | arbitrate sampled requests, latch winner and its access
// ISSUE   | drive RAM enable and byte-lane writes for one cycle
// CAPTURE | RAM read data available, register into owner's read port
// DONE    | one-cycle ack to the owner, then back to IDLE
module data_memory_arbiter #(
    parameter int DATA_LENGTH    = 32,
    parameter int ADDRESS_LENGTH = 11,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      core_select_i,

    input  logic                      core_req_i,
    input  logic                      core_wr_en_i,
    input  logic [DATA_LENGTH-1:0]    core_address_i,
    input  logic [DATA_LENGTH-1:0]    core_data_in_i,
    input  logic [1:0]                core_data_length_i,
    output logic                      core_ack_o,
    output logic [DATA_LENGTH-1:0]    core_data_out_o,

    input  logic                      spi_req_i,
    input  logic                      spi_wr_en_i,
    input  logic [ADDRESS_LENGTH-1:0] spi_address_i,
    input  logic [DATA_LENGTH-1:0]    spi_data_in_i,
    input  logic [1:0]                spi_data_length_i,
    output logic                      spi_ack_o,
    output logic [DATA_LENGTH-1:0]    spi_data_out_o,

    output logic                      mem_en_o,
    output logic [3:0]                mem_we_o,
    output logic [ADDRESS_LENGTH-1:0] mem_address_o,
    output logic [DATA_LENGTH-1:0]    mem_data_in_o,
    input  logic [DATA_LENGTH-1:0]    mem_data_out_i
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic                      owner_spi_q;
    logic                      wr_q;
    logic [ADDRESS_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0]    wdata_q;
    logic [3:0]                lanes_q;
    logic [STARVE_W-1:0]       starve_q, starve_d;
    logic [DATA_LENGTH-1:0]    core_rdata_q;
    logic [DATA_LENGTH-1:0]    spi_rdata_q;

    logic                      core_eligible;
    logic                      grant_spi;
    logic                      grant_core;
    logic                      req_wr_d;
    logic [ADDRESS_LENGTH-1:0] req_addr_d;
    logic [DATA_LENGTH-1:0]    req_wdata_d;
    logic [3:0]                req_lanes_d;

    // Byte address bits outside the RAM word index are intentionally dropped.
    logic unused_core_addr_bits;
    assign unused_core_addr_bits = ^{core_address_i[DATA_LENGTH-1:ADDRESS_LENGTH+2],
                                     core_address_i[1:0]};

    function automatic logic [3:0] core_lanes(input logic [1:0] len);
        case (len)
            2'b00:   return 4'b1111;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] spi_lanes(input logic [1:0] len);
        case (len)
            2'b01:   return 4'b0001;
            2'b10:   return 4'b0011;
            2'b11:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Arbitration: core has priority unless SPI has lost STARVE_LIMIT times in a row.
    always_comb begin
        core_eligible = core_req_i & core_select_i;
        grant_spi     = spi_req_i & ((starve_q == STARVE_MAX) | ~core_eligible);
        grant_core    = core_eligible & ~grant_spi;

        starve_d = starve_q;
        if (grant_spi) begin
            starve_d = '0;
        end else if (grant_core && spi_req_i && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        req_wr_d    = core_wr_en_i;
        req_addr_d  = core_address_i[ADDRESS_LENGTH+1:2];
        req_wdata_d = core_data_in_i;
        req_lanes_d = core_lanes(core_data_length_i);
        if (grant_spi) begin
            req_wr_d    = spi_wr_en_i;
            req_addr_d  = spi_address_i;
            req_wdata_d = spi_data_in_i;
            req_lanes_d = spi_lanes(spi_data_length_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_core || grant_spi) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE:   state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by rst_i so a reset in ISSUE or DONE suppresses the write and the ack.
    always_comb begin
        mem_en_o      = 1'b0;
        mem_we_o      = 4'b0000;
        core_ack_o    = 1'b0;
        spi_ack_o     = 1'b0;
        mem_address_o = '0;
        mem_data_in_o = '0;
        if (state_q != S_IDLE) begin
            mem_address_o = addr_q;
            mem_data_in_o = wdata_q;
        end
        case (state_q)
            S_ISSUE: begin
                mem_en_o = ~rst_i;
                if (wr_q && !rst_i) begin
                    mem_we_o = lanes_q;
                end
            end
            S_DONE: begin
                core_ack_o = ~owner_spi_q & ~rst_i;
                spi_ack_o  = owner_spi_q & ~rst_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_spi_q  <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lanes_q      <= 4'b0000;
            starve_q     <= '0;
            core_rdata_q <= '0;
            spi_rdata_q  <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                starve_q <= starve_d;
                if (grant_core || grant_spi) begin
                    owner_spi_q <= grant_spi;
                    wr_q        <= req_wr_d;
                    addr_q      <= req_addr_d;
                    wdata_q     <= req_wdata_d;
                    lanes_q     <= req_lanes_d;
                end
            end
            if (state_q == S_CAPTURE && !wr_q) begin
                if (owner_spi_q) begin
                    spi_rdata_q <= mem_data_out_i;
                end else begin
                    core_rdata_q <= mem_data_out_i;
                end
            end
        end
    end

    assign core_data_out_o = core_rdata_q;
    assign spi_data_out_o  = spi_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 1-cycle-read RAM.
// Vector table covers single transactions; hand sequences cover arbitration, core_select and reset.
module tb_data_memory_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_select_i = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_wr_en_i = 1'b0;
    logic [31:0] core_address_i = '0;
    logic [31:0] core_data_in_i = '0;
    logic [1:0]  core_data_length_i = '0;
    logic        core_ack_o;
    logic [31:0] core_data_out_o;
    logic        spi_req_i = 1'b0;
    logic        spi_wr_en_i = 1'b0;
    logic [10:0] spi_address_i = '0;
    logic [31:0] spi_data_in_i = '0;
    logic [1:0]  spi_data_length_i = '0;
    logic        spi_ack_o;
    logic [31:0] spi_data_out_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [10:0] mem_address_o;
    logic [31:0] mem_data_in_o;
    logic [31:0] mem_data_out_i = '0;

    data_memory_arbiter #(
        .DATA_LENGTH(32), .ADDRESS_LENGTH(11), .STARVE_LIMIT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .core_select_i(core_select_i),
        .core_req_i(core_req_i), .core_wr_en_i(core_wr_en_i),
        .core_address_i(core_address_i), .core_data_in_i(core_data_in_i),
        .core_data_length_i(core_data_length_i), .core_ack_o(core_ack_o),
        .core_data_out_o(core_data_out_o),
        .spi_req_i(spi_req_i), .spi_wr_en_i(spi_wr_en_i),
        .spi_address_i(spi_address_i), .spi_data_in_i(spi_data_in_i),
        .spi_data_length_i(spi_data_length_i), .spi_ack_o(spi_ack_o),
        .spi_data_out_o(spi_data_out_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_address_o(mem_address_o),
        .mem_data_in_o(mem_data_in_o), .mem_data_out_i(mem_data_out_i)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] ram [0:2047];
    initial for (int i = 0; i < 2048; i++) ram[i] = '0;

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            mem_data_out_i <= ram[mem_address_o];
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_address_o][8*b +: 8] = mem_data_in_o[8*b +: 8];
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] core_last = '0;
    logic [31:0] spi_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        spi;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  len;
        logic [3:0]  exp_we;
        logic [10:0] exp_maddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [15];

    task automatic run_txn(input vec_t v);
        int  lat;
        bit  got_ack;
        bit  issue_seen;
        if (v.spi) begin
            spi_req_i = 1'b1; spi_wr_en_i = v.wr; spi_address_i = v.addr[10:0];
            spi_data_in_i = v.data; spi_data_length_i = v.len;
        end else begin
            core_req_i = 1'b1; core_wr_en_i = v.wr; core_address_i = v.addr;
            core_data_in_i = v.data; core_data_length_i = v.len;
        end
        lat = 0; got_ack = 0; issue_seen = 0;
        while (!got_ack && lat < 8) begin
            @(posedge clk_i); #1; lat++;
            if (mem_en_o) begin
                issue_seen = 1;
                chk("issue_we", {28'd0, mem_we_o}, {28'd0, v.exp_we});
                chk("issue_addr", {21'd0, mem_address_o}, {21'd0, v.exp_maddr});
                if (v.wr) chk("issue_wdata", mem_data_in_o, v.data);
            end
            if (v.spi ? spi_ack_o : core_ack_o) got_ack = 1;
        end
        chk("ack_seen", {31'd0, got_ack}, 32'd1);
        chk("ack_latency", lat, 32'd3);
        chk("issue_seen", {31'd0, issue_seen}, 32'd1);
        chk("other_ack", {31'd0, v.spi ? core_ack_o : spi_ack_o}, 32'd0);
        if (!v.wr) begin
            if (v.spi) spi_last = v.exp_rd; else core_last = v.exp_rd;
        end
        chk("core_data_out", core_data_out_o, core_last);
        chk("spi_data_out", spi_data_out_o, spi_last);
        @(posedge clk_i); #1;
        core_req_i = 1'b0; spi_req_i = 1'b0;
        chk("idle_mem_en", {31'd0, mem_en_o}, 32'd0);
        chk("idle_mem_addr", {21'd0, mem_address_o}, 32'd0);
        chk("idle_mem_data", mem_data_in_o, 32'd0);
    endtask

    int   cc;
    int   sc;
    bit   got;
    bit   order [$];

    initial begin
        //            spi wr  addr          data          len    we       maddr    rd
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b00, 4'b1111, 11'h004, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2'b00, 4'b0000, 11'h004, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 2'b11, 4'b1111, 11'h005, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0005, 32'h1122_3344, 2'b01, 4'b0001, 11'h005, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         2'b11, 4'b0000, 11'h005, 32'hFFFF_FF44};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 2'b11, 4'b0000, 11'h004, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         2'b00, 4'b0000, 11'h004, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_E023, 32'hA5A5_0102, 2'b01, 4'b0011, 11'h008, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         2'b00, 4'b0000, 11'h008, 32'h0000_0102};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0024, 32'h0000_00C3, 2'b10, 4'b0001, 11'h009, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'hFFFF_F809, 32'h0,         2'b00, 4'b0000, 11'h009, 32'h0000_00C3};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0009, 32'hFFFF_FFFF, 2'b00, 4'b0000, 11'h009, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0009, 32'h0,         2'b10, 4'b0000, 11'h009, 32'h0000_00C3};
        vecs[13] = '{1'b1, 1'b1, 32'h0000_07FF, 32'hCAFE_BABE, 2'b10, 4'b0011, 11'h7FF, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 32'h0000_1FFC, 32'h0,         2'b00, 4'b0000, 11'h7FF, 32'h0000_BABE};

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we_o}, 32'd0);
        chk("rst_core_ack", {31'd0, core_ack_o}, 32'd0);
        chk("rst_spi_ack", {31'd0, spi_ack_o}, 32'd0);
        chk("rst_core_dout", core_data_out_o, 32'd0);
        chk("rst_spi_dout", spi_data_out_o, 32'd0);
        chk("rst_mem_addr", {21'd0, mem_address_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 15; i++) run_txn(vecs[i]);

        // Both requesters hold requests: expect 8 core grants then one SPI grant, twice.
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        core_last = '0; spi_last = '0;
        core_req_i = 1'b1; core_wr_en_i = 1'b0; core_address_i = 32'h10; core_data_length_i = 2'b00;
        spi_req_i = 1'b1; spi_wr_en_i = 1'b0; spi_address_i = 11'h5; spi_data_length_i = 2'b11;
        for (int c = 0; c < 100 && order.size() < 18; c++) begin
            @(posedge clk_i); #1;
            if (core_ack_o) order.push_back(1'b0);
            if (spi_ack_o) order.push_back(1'b1);
        end
        core_req_i = 1'b0; spi_req_i = 1'b0;
        chk("starve_grant_count", order.size(), 32'd18);
        for (int i = 0; i < order.size(); i++)
            chk($sformatf("starve_winner_%0d", i), {31'd0, order[i]}, {31'd0, (i % 9) == 8});
        chk("starve_core_dout", core_data_out_o, 32'hDEAD_BEEF);
        chk("starve_spi_dout", spi_data_out_o, 32'hFFFF_FF44);
        repeat (4) @(posedge clk_i);
        #1;

        // core_select low: only SPI is served even with core requesting.
        core_select_i = 1'b0;
        core_req_i = 1'b1; spi_req_i = 1'b1;
        cc = 0; sc = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk_i); #1;
            if (core_ack_o) cc++;
            if (spi_ack_o) sc++;
        end
        chk("sel0_core_acks", cc, 32'd0);
        chk("sel0_spi_served", {31'd0, sc > 0}, 32'd1);
        spi_req_i = 1'b0;
        core_select_i = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(posedge clk_i); #1;
            if (core_ack_o) got = 1;
        end
        chk("sel1_core_ack", {31'd0, got}, 32'd1);
        chk("sel1_core_dout", core_data_out_o, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset during CAPTURE of a core read aborts it without an ack.
        core_req_i = 1'b1; core_wr_en_i = 1'b0; core_address_i = 32'h10;
        @(posedge clk_i); #1;
        chk("abort_issue_en", {31'd0, mem_en_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("abort_core_ack", {31'd0, core_ack_o}, 32'd0);
        chk("abort_core_dout", core_data_out_o, 32'd0);
        chk("abort_mem_en", {31'd0, mem_en_o}, 32'd0);
        rst_i = 1'b0; core_req_i = 1'b0;
        cc = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            if (core_ack_o) cc++;
        end
        chk("abort_no_late_ack", cc, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
